// File: rtl/hex_display_arbiter_if.sv
// Requester-side bundle for the hex display arbiter.
// master = requesters/board logic, slave = arbiter.
interface hex_display_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC)
);
    logic [N_SRC-1:0]    req;
    logic [16*N_SRC-1:0] data;
    logic                freeze;
    logic [N_SRC-1:0]    ack;
    logic [15:0]         disp_value;
    logic [SRC_W-1:0]    disp_src;
    logic                disp_valid;

    modport master (
        output req, data, freeze,
        input  ack, disp_value, disp_src, disp_valid
    );

    modport slave (
        input  req, data, freeze,
        output ack, disp_value, disp_src, disp_valid
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Time-shares one quad 7-segment display between N_SRC requesters.
// Define HEX_DISPLAY_ARB_FIXED_PRI_EN for fixed (lowest index) priority.
module hex_display_arbiter #(
    parameter int N_SRC = 4,
    parameter int SRC_W = $clog2(N_SRC),
    parameter int DWELL = 25_000_000,
    parameter int CNT_W = $clog2(DWELL)
) (
    input logic                 clk,
    input logic                 rst_n,
    hex_display_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SRC_W-1:0]   r_last;
    logic [N_SRC-1:0]   r_ack;
    logic [15:0]        r_disp_value;
    logic [SRC_W-1:0]   r_disp_src;
    logic               r_disp_valid;

    logic               w_any;
    logic               w_arb;
    logic               w_found;
    logic [SRC_W-1:0]   w_idx;
    logic [SRC_W-1:0]   w_win;
    logic [15:0]        w_win_data;
    logic [N_SRC-1:0]   w_onehot;

    assign w_any = |bus.req;
    assign w_arb = w_any && ((r_state == IDLE) || (r_cnt == '0));

`ifdef HEX_DISPLAY_ARB_FIXED_PRI_EN
    // Winner: lowest-indexed active request.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_win   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_idx = SRC_W'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end
`else
    // Winner: first active request after the last grant, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_win   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            w_idx = SRC_W'((int'(r_last) + k) % N_SRC);
            if (!w_found && bus.req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end
`endif

    // Select the winner's data word and build its one-hot ack.
    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (w_win == SRC_W'(i)) begin
                w_win_data = bus.data[16*i +: 16];
            end
        end
        w_onehot = N_SRC'(1) << w_win;
    end

    // Grant/dwell state machine with registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last       <= SRC_W'(N_SRC - 1);
            r_ack        <= '0;
            r_disp_value <= 16'h0000;
            r_disp_src   <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_arb) begin
                r_disp_value <= w_win_data;
                r_disp_src   <= w_win;
                r_disp_valid <= 1'b1;
                r_last       <= w_win;
                r_ack        <= w_onehot;
                r_cnt        <= CNT_W'(DWELL - 1);
                r_state      <= HOLD;
            end else begin
                case (r_state)
                    HOLD: begin
                        if (r_cnt != '0) begin
                            if (!bus.freeze) begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ack        = r_ack;
    assign bus.disp_value = r_disp_value;
    assign bus.disp_src   = r_disp_src;
    assign bus.disp_valid = r_disp_valid;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter (N_SRC=4, DWELL=4).
// Stimulus pushes expected grants; a negedge monitor checks them.
module tb_hex_display_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    typedef struct {
        int          src;
        logic [15:0] val;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_acks   = 0;
    int   last_ack_cyc = 0;
    int   c0;

    hex_display_arbiter_if #(.N_SRC(N)) bus ();

    hex_display_arbiter #(
        .N_SRC(N),
        .DWELL(D)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int req_v);
        checks++;
        if (act != req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    task automatic wait_acks(int target);
        int b;
        b = 0;
        while (n_acks < target && b < 40) begin
            @(negedge clk);
            #1;
            b++;
        end
        checks++;
        if (n_acks < target) begin
            failures++;
            $display("FAIL ack_timeout actual=%0d required=%0d",
                     n_acks, target);
        end
    endtask

    task automatic push(int s, logic [15:0] v, int g);
        exp_t e;
        e.src = s;
        e.val = v;
        e.gap = g;
        q.push_back(e);
    endtask

    task automatic chk_out(string nm, int a, int v, int s, int vl);
        chk({nm, "_ack"}, bus.ack, a);
        chk({nm, "_value"}, bus.disp_value, v);
        chk({nm, "_src"}, bus.disp_src, s);
        chk({nm, "_valid"}, bus.disp_valid, vl);
    endtask

    // Monitor: every ack pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && |bus.ack) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=%b required=none",
                         bus.ack);
            end else begin
                e = q.pop_front();
                chk("mon_ack", bus.ack, 1 << e.src);
                chk("mon_src", bus.disp_src, e.src);
                chk("mon_value", bus.disp_value, e.val);
                chk("mon_valid", bus.disp_valid, 1);
                if (e.gap != 0) begin
                    chk("mon_gap", cyc - last_ack_cyc, e.gap);
                end
            end
            last_ack_cyc = cyc;
            n_acks++;
        end
    end

    initial begin
        rst_n      = 1'b0;
        bus.req    = '0;
        bus.freeze = 1'b0;
        bus.data   = '0;

        // Reset state, then idle with no requests.
        #12;
        chk_out("reset", 0, 16'h0000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk_out("idle_noreq", 0, 16'h0000, 0, 0);

        // Round-robin with all sources requesting.
        bus.data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        bus.req  = 4'b1111;
`ifdef HEX_DISPLAY_ARB_FIXED_PRI_EN
        push(0, 16'h1000, 0);
        push(0, 16'h1000, 4);
        push(0, 16'h1000, 4);
        push(0, 16'h1000, 4);
        push(0, 16'h1000, 4);
`else
        push(0, 16'h1000, 0);
        push(1, 16'h1001, 4);
        push(2, 16'h1002, 4);
        push(3, 16'h1003, 4);
        push(0, 16'h1000, 4);
`endif
        wait_acks(5);
        bus.req = '0;

        // Single continuous requester on source 2.
        bus.data[47:32] = 16'hBEEF;
        bus.req = 4'b0100;
        push(2, 16'hBEEF, 4);
        push(2, 16'hBEEF, 4);
        wait_acks(7);

        // Freeze for three edges; mid-hold data change is ignored.
        bus.freeze = 1'b1;
        bus.data[47:32] = 16'hCAFE;
        push(2, 16'hCAFE, 7);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_value", bus.disp_value, 16'hBEEF);
        bus.freeze = 1'b0;
        wait_acks(8);

        // Source 1 granted, then dropped; display retained in IDLE.
        bus.data[31:16] = 16'h1111;
        bus.req = 4'b0010;
        push(1, 16'h1111, 4);
        wait_acks(9);
        bus.req = '0;
        repeat (8) @(negedge clk);
        #1;
        chk_out("idle_keep", 0, 16'h1111, 1, 1);

        // New request from IDLE is granted on the very next edge.
        bus.data[15:0] = 16'h0A0A;
        bus.req = 4'b0001;
        c0 = cyc;
        push(0, 16'h0A0A, 0);
        wait_acks(10);
        chk("idle_latency", last_ack_cyc - c0, 1);

        // Asynchronous reset in the middle of HOLD.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 16'h0000, 0, 0);
        bus.req = 4'b1111;
        push(0, 16'h0A0A, 0);
        #2;
        rst_n = 1'b1;
        wait_acks(11);
        bus.req = '0;

        repeat (8) @(negedge clk);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
